// File: rtl/snapshot_sched.sv
// rtl/snapshot_sched.sv - round-robin scheduler sharing one snapshot transmitter among NUM_CH sources
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   ss_req       : per-channel request strobes, buffer in ss_buff_in slice i
//   ovf_clr      : clears the sticky ovf and start_err flags
//   tx_idle      : transmitter idle indication
//   ss_tx_start  : one-cycle start pulse, ss_buff_out is stable around it
//   ss_buff_out  : buffer presented to the transmitter
//   grant_ch     : channel of the current/last frame
//   busy         : high whenever the FSM is not arbitrating
//   ovf          : sticky per-channel dropped-request flags
//   start_err    : sticky flag, transmitter did not leave idle after a start
module snapshot_sched #(
  parameter int NUM_CH         = 4,
  parameter int SAMPLE_WIDTH   = 16,
  parameter int NUM_TAPS       = 10,
  parameter int ABS_TIME_WIDTH = 32,
  parameter int SS_BUFF_SZ     = SAMPLE_WIDTH*NUM_TAPS+ABS_TIME_WIDTH,
  parameter int GAP_CYCLES     = 4,
  parameter int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            ss_req,
  input  logic [NUM_CH*SS_BUFF_SZ-1:0] ss_buff_in,
  input  logic                         ovf_clr,
  input  logic                         tx_idle,
  output logic                         ss_tx_start,
  output logic [SS_BUFF_SZ-1:0]        ss_buff_out,
  output logic [CH_W-1:0]              grant_ch,
  output logic                         busy,
  output logic [NUM_CH-1:0]            ovf,
  output logic                         start_err
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {ARB, START, WAIT_BUSY, WAIT_IDLE, GAP} state_t;

  state_t                 state_q;
  logic [NUM_CH-1:0]      pending_q;
  logic [NUM_CH-1:0]      ovf_q;
  logic [SS_BUFF_SZ-1:0]  hold_q [NUM_CH];
  logic [CH_W-1:0]        last_grant_q;
  logic [CH_W-1:0]        grant_ch_q;
  logic [SS_BUFF_SZ-1:0]  buff_out_q;
  logic                   start_q;
  logic                   busy_q;
  logic                   start_err_q;
  logic [GAP_W-1:0]       gap_cnt_q;
  logic [1:0]             wb_cnt_q;

  logic                   win_vld;
  logic [CH_W-1:0]        win_ch;
  logic                   grant_now;
  logic [NUM_CH-1:0]      grant_vec;
  int                     idx;

  // Walk downwards so the last hit is the channel closest after last_grant.
  always_comb begin
    win_vld = 1'b0;
    win_ch  = '0;
    idx     = 0;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = int'(last_grant_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (pending_q[CH_W'(idx)]) begin
        win_vld = 1'b1;
        win_ch  = CH_W'(idx);
      end
    end
  end

  always_comb begin
    grant_now = (state_q == ARB) && win_vld && tx_idle;
    grant_vec = '0;
    if (grant_now) grant_vec[win_ch] = 1'b1;
  end

  // Holding registers carry data only while pending is set, so they need no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (ss_req[i] && (!pending_q[i] || grant_vec[i]))
        hold_q[i] <= ss_buff_in[i*SS_BUFF_SZ +: SS_BUFF_SZ];
    end
  end

  // A request landing on the granted channel is accepted: the old data is
  // already on its way into buff_out_q this same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      ovf_q     <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ss_req[i] && (!pending_q[i] || grant_vec[i])) pending_q[i] <= 1'b1;
        else if (grant_vec[i])                             pending_q[i] <= 1'b0;

        if (ss_req[i] && pending_q[i] && !grant_vec[i]) ovf_q[i] <= 1'b1;
        else if (ovf_clr)                               ovf_q[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB;
      start_q      <= 1'b0;
      buff_out_q   <= '0;
      grant_ch_q   <= '0;
      busy_q       <= 1'b0;
      last_grant_q <= CH_W'(NUM_CH-1);
      gap_cnt_q    <= '0;
      wb_cnt_q     <= '0;
      start_err_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      // A timeout set later in this block overrides the clear.
      if (ovf_clr) start_err_q <= 1'b0;
      unique case (state_q)
        ARB: begin
          if (grant_now) begin
            buff_out_q   <= hold_q[win_ch];
            grant_ch_q   <= win_ch;
            last_grant_q <= win_ch;
            start_q      <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= START;
          end
        end
        START: begin
          wb_cnt_q <= '0;
          state_q  <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!tx_idle) begin
            state_q <= WAIT_IDLE;
          end else if (wb_cnt_q == 2'd3) begin
            // Transmitter never took the frame: flag it and drop the frame.
            start_err_q <= 1'b1;
            gap_cnt_q   <= '0;
            if (GAP_CYCLES == 0) begin
              state_q <= ARB;
              busy_q  <= 1'b0;
            end else begin
              state_q <= GAP;
            end
          end else begin
            wb_cnt_q <= wb_cnt_q + 2'd1;
          end
        end
        WAIT_IDLE: begin
          if (tx_idle) begin
            gap_cnt_q <= '0;
            if (GAP_CYCLES == 0) begin
              state_q <= ARB;
              busy_q  <= 1'b0;
            end else begin
              state_q <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt_q == GAP_W'(GAP_CYCLES-1)) begin
            state_q <= ARB;
            busy_q  <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ARB;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ss_tx_start = start_q;
  assign ss_buff_out = buff_out_q;
  assign grant_ch    = grant_ch_q;
  assign busy        = busy_q;
  assign ovf         = ovf_q;
  assign start_err   = start_err_q;

endmodule
